// File: rtl/branch_cmp_seq.sv
// branch_cmp_seq: slice-serial RV32I branch comparator, MSB slice first, valid/ready on both sides.
// Define BRANCH_CMP_EARLY_EXIT_EN to leave RUN at the first differing slice.
module branch_cmp_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       cmpop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             br_en,
  output logic             illegal,
  output logic [TAG_W-1:0] out_tag
);
  localparam int N = WIDTH / (SLICE < 1 ? 1 : SLICE);
  localparam int KW = N > 1 ? $clog2(N) : 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
`ifdef BRANCH_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  if (SLICE < 1 || WIDTH % (SLICE < 1 ? 1 : SLICE) != 0) begin : g_bad_cfg
    $error("branch_cmp_seq: WIDTH must be a positive multiple of SLICE");
  end
  logic [1:0]       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             eq_q, eq_d, lt_q, lt_d, br_q, br_d, ill_q, ill_d;
  logic [SLICE-1:0] flip, sa, sb;
  logic             diff, last;
  always_comb begin
    // signed ops bias the top slice so an unsigned compare orders two's complement
    flip = (k_q == KW'(N - 1) && op_q[2:1] == 2'b10) ? SLICE'(1) << (SLICE - 1) : '0;
    sa = a_q[int'(k_q) * SLICE +: SLICE] ^ flip;
    sb = b_q[int'(k_q) * SLICE +: SLICE] ^ flip;
    diff = sa != sb;
    last = k_q == '0 || (EARLY && diff);
    state_d = state_q;
    k_d = k_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    tag_d = tag_q;
    eq_d = eq_q;
    lt_d = lt_q;
    br_d = br_q;
    ill_d = ill_q;
    if (flush) state_d = IDLE;
    else if (state_q == IDLE && in_valid) begin
      a_d = a;
      b_d = b;
      op_d = cmpop;
      tag_d = in_tag;
      k_d = KW'(N - 1);
      eq_d = 1'b1;
      lt_d = 1'b0;
      br_d = 1'b0;
      ill_d = cmpop[2:1] == 2'b01;
      state_d = ill_d ? DONE : RUN;
    end else if (state_q == RUN) begin
      eq_d = eq_q & ~diff;
      lt_d = (eq_q & diff) ? sa < sb : lt_q;
      k_d = last ? k_q : k_q - 1'b1;
      state_d = last ? DONE : RUN;
      br_d = last ? (op_q[2] ? lt_d : eq_d) ^ op_q[0] : br_q;
      ill_d = last ? 1'b0 : ill_q;
    end else if (state_q == DONE && out_ready) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      tag_q <= '0;
      eq_q <= 1'b1;
      lt_q <= 1'b0;
      br_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      tag_q <= tag_d;
      eq_q <= eq_d;
      lt_q <= lt_d;
      br_q <= br_d;
      ill_q <= ill_d;
    end
  end
  assign in_ready = state_q == IDLE && !rst;
  assign out_valid = state_q == DONE;
  assign br_en = br_q;
  assign illegal = ill_q;
  assign out_tag = tag_q;
endmodule

// File: tb/tb_branch_cmp_seq.sv
// tb_branch_cmp_seq: directed vectors for branch_cmp_seq (WIDTH=32, SLICE=8).
module tb_branch_cmp_seq;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, br_en, illegal;
  logic [2:0]  cmpop = 3'b000;
  logic [31:0] a = '0, b = '0;
  logic [3:0]  in_tag = '0, out_tag;
  int          n_vec = 0, n_err = 0;
`ifdef BRANCH_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam logic [2:0] BEQ = 3'b000, BNE = 3'b001, BLT = 3'b100, BGE = 3'b101, BLTU = 3'b110, BGEU = 3'b111;
  always #5 clk = ~clk;
  branch_cmp_seq #(.WIDTH(32), .SLICE(8), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .cmpop(cmpop), .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .br_en(br_en), .illegal(illegal), .out_tag(out_tag)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb, input logic [3:0] t);
    cmpop = op;
    a = va;
    b = vb;
    in_tag = t;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask
  task automatic wait_out(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
    end
  endtask
  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                        input logic [3:0] t, input logic exp_br, input logic exp_ill, input int lat);
    int cyc;
    issue(op, va, vb, t);
    wait_out(cyc);
    chk({nm, "_lat"}, cyc, lat);
    chk({nm, "_br"}, br_en, exp_br);
    chk({nm, "_ill"}, illegal, exp_ill);
    chk({nm, "_tag"}, out_tag, t);
    step();
    chk({nm, "_rdy"}, in_ready, 1'b1);
  endtask
  task automatic quiet(input string nm);
    logic seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen |= out_valid;
      step();
    end
    chk(nm, seen, 1'b0);
  endtask
  initial begin
    int cyc;
    step();
    step();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_br_en", br_en, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_tag", out_tag, 4'h0);
    rst = 1'b0;
    #1;
    chk("rst_release_rdy", in_ready, 1'b1);
    step();
    run_op("beq_eq", BEQ, 32'h12345678, 32'h12345678, 4'h5, 1'b1, 1'b0, 5);
    run_op("bne_eq", BNE, 32'h12345678, 32'h12345678, 4'h6, 1'b0, 1'b0, 5);
    run_op("blt_neg", BLT, 32'hFFFFFFFF, 32'h00000001, 4'h1, 1'b1, 1'b0, EARLY ? 2 : 5);
    run_op("bltu_big", BLTU, 32'hFFFFFFFF, 32'h00000001, 4'h2, 1'b0, 1'b0, EARLY ? 2 : 5);
    run_op("bge_min", BGE, 32'h80000000, 32'h7FFFFFFF, 4'h3, 1'b0, 1'b0, EARLY ? 2 : 5);
    run_op("bgeu_min", BGEU, 32'h80000000, 32'h7FFFFFFF, 4'h4, 1'b1, 1'b0, EARLY ? 2 : 5);
    run_op("blt_s0", BLT, 32'h00000100, 32'h00000101, 4'h7, 1'b1, 1'b0, 5);
    run_op("blt_negneg", BLT, 32'hFFFFFF00, 32'hFFFFFFFF, 4'h8, 1'b1, 1'b0, 5);
    run_op("bltu_7f80", BLTU, 32'h7F000000, 32'h80000000, 4'h9, 1'b1, 1'b0, EARLY ? 2 : 5);
    run_op("blt_7f80", BLT, 32'h7F000000, 32'h80000000, 4'hA, 1'b0, 1'b0, EARLY ? 2 : 5);
    run_op("bge_eq", BGE, 32'h00000005, 32'h00000005, 4'hB, 1'b1, 1'b0, 5);
    run_op("beq_ne", BEQ, 32'h00000001, 32'h00000002, 4'hC, 1'b0, 1'b0, 5);
    run_op("ill_010", 3'b010, 32'h0, 32'h0, 4'hD, 1'b0, 1'b1, 1);
    run_op("ill_011", 3'b011, 32'h1, 32'h2, 4'hE, 1'b0, 1'b1, 1);
    run_op("beq_after_ill", BEQ, 32'hCAFEF00D, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 5);
    // held result under backpressure, with a competing request that must be refused
    out_ready = 1'b0;
    issue(BLT, 32'hFFFFFFFF, 32'h00000001, 4'hA);
    wait_out(cyc);
    chk("bp_lat", cyc, EARLY ? 2 : 5);
    cmpop = BEQ;
    a = '0;
    b = '0;
    in_tag = 4'h3;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_br", br_en, 1'b1);
      chk("bp_tag", out_tag, 4'hA);
      chk("bp_ill", illegal, 1'b0);
      chk("bp_rdy", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", out_valid, 1'b0);
    chk("bp_release_rdy", in_ready, 1'b1);
    quiet("bp_no_accept");
    // flush in IDLE swallows the request
    cmpop = BEQ;
    in_valid = 1'b1;
    flush = 1'b1;
    step();
    in_valid = 1'b0;
    flush = 1'b0;
    chk("fl_idle_rdy", in_ready, 1'b1);
    quiet("fl_idle_quiet");
    // flush in the second RUN cycle
    issue(BEQ, 32'h1, 32'h1, 4'h2);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_run_rdy", in_ready, 1'b1);
    chk("fl_run_valid", out_valid, 1'b0);
    quiet("fl_run_quiet");
    // flush while the result is offered
    issue(BNE, 32'h1, 32'h2, 4'h4);
    wait_out(cyc);
    chk("fl_done_seen", out_valid, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_done_valid", out_valid, 1'b0);
    chk("fl_done_rdy", in_ready, 1'b1);
    run_op("after_flush", BGEU, 32'h00000010, 32'h00000020, 4'h6, 1'b0, 1'b0, 5);
    // reset mid-RUN after a taken result with a nonzero tag
    run_op("pre_rst", BLT, 32'h00000100, 32'h00000101, 4'h7, 1'b1, 1'b0, 5);
    issue(BGE, 32'h5, 32'h3, 4'h9);
    step();
    rst = 1'b1;
    step();
    chk("mrst_valid", out_valid, 1'b0);
    chk("mrst_br", br_en, 1'b0);
    chk("mrst_ill", illegal, 1'b0);
    chk("mrst_tag", out_tag, 4'h0);
    chk("mrst_rdy", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("mrst_release_rdy", in_ready, 1'b1);
    step();
    run_op("post_rst", BGE, 32'h5, 32'h3, 4'h9, 1'b1, 1'b0, 5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
